// File: rtl/ram_bus_ctrl.sv
// Request/response front end for an asynchronous 16x8 RAM on a shared bidirectional data bus.
// Sequences setup/strobe/hold phases with all RAM-side signals launched from flops.
module ram_bus_ctrl #(
    parameter int unsigned RD_WAIT = 1
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       req_valid_in,
    output logic       req_ready_out,
    input  logic       req_wr_in,
    input  logic [3:0] req_addr_in,
    input  logic [7:0] req_wdata_in,
    output logic       rsp_valid_out,
    output logic [7:0] rsp_rdata_out,
    output logic       ram_we_out,
    output logic       ram_enable_out,
    output logic [3:0] ram_addr_out,
    inout  wire  [7:0] ram_data
);

    typedef enum logic [2:0] {
        StIdle,
        StWrSetup,
        StWrPulse,
        StWrHold,
        StRdSetup,
        StRdAccess,
        StDone
    } state_e;

    // RD_ACCESS runs RD_WAIT strobe cycles plus one turnaround cycle with the strobe low.
    localparam logic [3:0] RdEnd  = 4'(RD_WAIT);
    localparam logic [3:0] RdLast = 4'(RD_WAIT - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q;
    logic       ready_q, ready_d;
    logic       we_q, we_d;
    logic       en_q, en_d;
    logic       drive_q, drive_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       capture;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_in && ready_q) begin
                    addr_d  = req_addr_in;
                    wdata_d = req_wdata_in;
                    state_d = req_wr_in ? StWrSetup : StRdSetup;
                end
            end
            StWrSetup: state_d = StWrPulse;
            StWrPulse: state_d = StWrHold;
            StWrHold:  state_d = StDone;
            StRdSetup: begin
                cnt_d   = '0;
                state_d = StRdAccess;
            end
            StRdAccess: begin
                if (cnt_q == RdEnd) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Registered outputs are decoded from the next state so they line up with the state itself.
    always_comb begin
        ready_d     = (state_d == StIdle);
        we_d        = (state_d == StWrPulse);
        en_d        = (state_d == StRdAccess) && (cnt_d != RdEnd);
        drive_d     = (state_d == StWrSetup) || (state_d == StWrPulse) || (state_d == StWrHold);
        rsp_valid_d = (state_d == StDone);
        capture     = (state_q == StRdAccess) && (cnt_q == RdLast);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            we_q        <= 1'b0;
            en_q        <= 1'b0;
            drive_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            we_q        <= we_d;
            en_q        <= en_d;
            drive_q     <= drive_d;
            rsp_valid_q <= rsp_valid_d;
            if (capture) begin
                rdata_q <= ram_data;
            end
        end
    end

    assign req_ready_out  = ready_q;
    assign rsp_valid_out  = rsp_valid_q;
    assign rsp_rdata_out  = rdata_q;
    assign ram_we_out     = we_q;
    assign ram_enable_out = en_q;
    assign ram_addr_out   = addr_q;
    assign ram_data       = drive_q ? wdata_q : 8'hzz;

endmodule
